// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared FIFO geometry, arbiter state encoding and sizing helper
package fifo_wr_arbiter_pkg;

    localparam int FIFO_DATA_W   = 16;
    localparam int FIFO_DEPTH    = 16;
    localparam int FIFO_FULL_LVL = 15;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Burst counter only needs to reach MAX_BURST-1; keep at least one bit.
    function automatic int cnt_width(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin selector (req, rr_ptr) -> (any, idx)
module fifo_wr_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // Scan downward so the requester closest to rr_ptr is assigned last and wins.
    always_comb begin
        any = |req;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % N_REQ]) begin
                idx = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the FIFO write port
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int MAX_BURST = 4,
    parameter int IDX_W     = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data,
    output logic [N_REQ-1:0]        ack,
    input  logic                    fifo_full,
    output logic                    fifo_write,
    output logic [DATA_W-1:0]       fifo_wdata,
    output logic [IDX_W-1:0]        owner,
    output logic                    busy
);

    localparam int CNT_W = cnt_width(MAX_BURST);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] owner_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_req;
    logic             write_en;
    logic             release_now;
    logic [DATA_W-1:0] owner_data;
    logic [IDX_W-1:0] owner_succ;

    fifo_wr_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    assign owner_req   = req[owner];
    assign owner_data  = data[owner*DATA_W +: DATA_W];
    assign owner_succ  = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign write_en    = (state == ST_BURST) && owner_req && !fifo_full;
    assign release_now = (state == ST_BURST) &&
                         (!owner_req || (write_en && burst_cnt == CNT_W'(MAX_BURST - 1)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_nxt     = pick_idx;
                    burst_cnt_nxt = '0;
                    state_nxt     = ST_BURST;
                end
            end
            ST_BURST: begin
                if (release_now) begin
                    state_nxt     = ST_IDLE;
                    rr_ptr_nxt    = owner_succ;
                    burst_cnt_nxt = '0;
                end else if (write_en) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Gating with reset guarantees no word is acked in a cycle whose state update is discarded.
    assign fifo_write = write_en && !reset;
    assign busy       = (state == ST_BURST) && !reset;
    assign fifo_wdata = fifo_write ? owner_data : '0;

    always_comb begin
        ack = '0;
        if (fifo_write) begin
            ack[owner] = 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized scoreboard bench for fifo_wr_arbiter with a FIFO occupancy model
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 4;
    localparam int IW = 2;
    localparam int FULL_LVL = 15;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] data = '0;
    logic            fifo_full = 1'b0;
    logic [N-1:0]    ack;
    logic            fifo_write;
    logic [DW-1:0]   fifo_wdata;
    logic [IW-1:0]   owner;
    logic            busy;

    always #5 clock = ~clock;

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .MAX_BURST (MB),
        .IDX_W     (IW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .data       (data),
        .ack        (ack),
        .fifo_full  (fifo_full),
        .fifo_write (fifo_write),
        .fifo_wdata (fifo_wdata),
        .owner      (owner),
        .busy       (busy)
    );

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] word;
    } exp_t;

    int vectors = 0;
    int miscompares = 0;

    exp_t          exp_q[$];
    logic [DW-1:0] prod_q[N][$];

    // Reference model: current grant holder (-1 = none), words granted so far, next start point.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_words = 0;
    int m_last  = 0;

    logic          exp_busy  = 1'b0;
    logic [IW-1:0] exp_owner = '0;
    logic          run_chk   = 1'b0;
    logic [N-1:0]  ack_seen  = '0;
    logic          wr_seen   = 1'b0;
    int            fcnt      = 0;
    int            seq       = 0;
    bit            did_reset = 1'b0;
    int            per_src_acks[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the model's predictions away from the active edge.
    always @(negedge clock) begin
        exp_t e;
        if (run_chk) begin
            if (reset) begin
                check("reset_ack", 64'(ack), 64'(0));
                check("reset_fifo_write", 64'(fifo_write), 64'(0));
                check("reset_fifo_wdata", 64'(fifo_wdata), 64'(0));
                check("reset_busy", 64'(busy), 64'(0));
                ack_seen = '0;
                wr_seen  = 1'b0;
            end else begin
                check("busy", 64'(busy), 64'(exp_busy));
                check("owner", 64'(owner), 64'(exp_owner));
                check("fifo_write", 64'(fifo_write), 64'(exp_q.size()));
                if (fifo_write && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("ack", 64'(ack), 64'(1) << e.idx);
                    check("fifo_wdata", 64'(fifo_wdata), 64'(e.word));
                    check("write_while_full", 64'(fifo_full), 64'(0));
                end else if (!fifo_write) begin
                    check("ack_without_write", 64'(ack), 64'(0));
                end
                ack_seen = ack;
                wr_seen  = fifo_write;
            end
        end
    end

    task automatic model_step();
        exp_busy  = (m_owner >= 0);
        exp_owner = IW'(m_last);
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_last  = m_owner;
                    m_words = 0;
                    break;
                end
            end
        end else if (!req[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (!fifo_full) begin
            exp_q.push_back({IW'(m_owner), prod_q[m_owner][0]});
            m_words++;
            if (m_words == MB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic drive_cycle(input int enq_pct, input int rd_pct, input int pause_pct, input bit try_reset);
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ack_seen[i] && prod_q[i].size() > 0) begin
                void'(prod_q[i].pop_front());
                per_src_acks[i]++;
            end
        end
        if (wr_seen) fcnt++;
        ack_seen = '0;
        wr_seen  = 1'b0;
        check("fifo_level_bound", 64'(fcnt <= FULL_LVL), 64'(1));
        if (fcnt > 0 && $urandom_range(99) < rd_pct) fcnt--;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(99) < enq_pct && prod_q[i].size() < 8) begin
                prod_q[i].push_back({2'(i), 14'(seq)});
                seq++;
            end
        end
        for (int i = 0; i < N; i++) begin
            req[i] = (prod_q[i].size() > 0) && ($urandom_range(99) >= pause_pct);
            data[i*DW +: DW] = (prod_q[i].size() > 0) ? prod_q[i][0] : DW'($urandom);
        end
        fifo_full = (fcnt >= FULL_LVL);
        reset = 1'b0;
        if (try_reset && m_owner >= 0 && req[m_owner] && !fifo_full) begin
            reset     = 1'b1;
            did_reset = 1'b1;
            m_owner   = -1;
            m_ptr     = 0;
            m_words   = 0;
            m_last    = 0;
            exp_busy  = 1'b0;
            exp_owner = '0;
        end else begin
            model_step();
        end
    endtask

    function automatic bit all_drained();
        for (int i = 0; i < N; i++) begin
            if (prod_q[i].size() > 0) return 1'b0;
        end
        return (m_owner < 0);
    endfunction

    initial begin
        int guard;
        for (int i = 0; i < N; i++) per_src_acks[i] = 0;
        reset   = 1'b1;
        run_chk = 1'b1;
        repeat (3) @(posedge clock);

        // Saturated requesters with a fast reader: round-robin rotation of full bursts.
        for (int c = 0; c < 200; c++) drive_cycle(100, 100, 0, 1'b0);
        // Mixed traffic, back-pressure from a slow reader, occasional owner req drops.
        for (int c = 0; c < 600; c++) drive_cycle(40, 35, 8, 1'b0);

        guard = 0;
        while (!did_reset && guard < 500) begin
            drive_cycle(60, 60, 0, 1'b1);
            guard++;
        end
        check("reset_mid_burst_reached", 64'(did_reset), 64'(1));

        for (int c = 0; c < 300; c++) drive_cycle(50, 30, 5, 1'b0);

        guard = 0;
        while (!all_drained() && guard < 2000) begin
            drive_cycle(0, 100, 0, 1'b0);
            guard++;
        end
        check("drain_within_bound", 64'(all_drained()), 64'(1));
        repeat (2) drive_cycle(0, 100, 0, 1'b0);
        @(negedge clock);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        for (int i = 0; i < N; i++) begin
            check("requester_served", 64'(per_src_acks[i] > 0), 64'(1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
